// File: rtl/cpu_bus_sampler.sv
// Samples the asynchronous NES CPU bus into the system clock domain, deglitches M2
// and emits one-clock strobes with latched address/data/R/W at the end of each CPU cycle.
module cpu_bus_sampler #(
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned IDLE_CLKS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_m2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic        cpu_rw,
    output logic        m2_f,
    output logic        cyc_stb,
    output logic        wr_stb,
    output logic        rom_wr_stb,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dat,
    output logic        bus_rw,
    output logic        wr_consec,
    output logic        bus_idle
);
    localparam int unsigned FILT_W = 4;
    localparam int unsigned IDLE_W = 16;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_CLKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CLKS - 1);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    logic              m2_m, m2_s;
    logic              rw_m, rw_s;
    logic [15:0]       addr_m, addr_s;
    logic [7:0]        dat_m, dat_s;
    logic [FILT_W-1:0] filt_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [15:0]       sh_addr;
    logic [7:0]        sh_dat;
    logic              sh_rw;
    logic              armed;
    logic              low_seen;
    logic              prev_wr;
    state_t            state;

    // Two-flop synchronizers; left unreset so they track the bus during reset.
    always_ff @(posedge clk) begin
        m2_m   <= cpu_m2;
        m2_s   <= m2_m;
        rw_m   <= cpu_rw;
        rw_s   <= rw_m;
        addr_m <= cpu_addr;
        addr_s <= addr_m;
        dat_m  <= cpu_dat;
        dat_s  <= dat_m;
    end

    // M2 deglitch: the filtered level flips only after FILTER_LEN disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt <= '0;
            m2_f     <= 1'b0;
        end else if (m2_s != m2_f) begin
            if (filt_cnt == FILT_LAST) begin
                m2_f     <= ~m2_f;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Cycle tracker, strobe generation, consecutive-write and idle bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOW;
            armed      <= 1'b0;
            low_seen   <= 1'b0;
            sh_addr    <= '0;
            sh_dat     <= '0;
            sh_rw      <= 1'b0;
            bus_addr   <= '0;
            bus_dat    <= '0;
            bus_rw     <= 1'b1;
            cyc_stb    <= 1'b0;
            wr_stb     <= 1'b0;
            rom_wr_stb <= 1'b0;
            wr_consec  <= 1'b0;
            prev_wr    <= 1'b0;
            idle_cnt   <= '0;
            bus_idle   <= 1'b0;
        end else begin
            cyc_stb    <= 1'b0;
            wr_stb     <= 1'b0;
            rom_wr_stb <= 1'b0;

            // A rise is only genuine once M2 has been seen low since reset.
            if (!m2_s) begin
                low_seen <= 1'b1;
            end

            if (m2_f) begin
                idle_cnt <= '0;
                bus_idle <= 1'b0;
            end else if (idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == IDLE_LAST) begin
                    bus_idle <= 1'b1;
                    prev_wr  <= 1'b0;
                end
            end

            case (state)
                ST_LOW: begin
                    if (m2_f) begin
                        state <= ST_HIGH;
                        armed <= low_seen;
                    end
                end
                ST_HIGH: begin
                    if (m2_s) begin
                        sh_addr <= addr_s;
                        sh_dat  <= dat_s;
                        sh_rw   <= rw_s;
                    end
                    if (!m2_f) begin
                        state <= ST_LOW;
                        armed <= 1'b0;
                        if (armed) begin
                            bus_addr   <= sh_addr;
                            bus_dat    <= sh_dat;
                            bus_rw     <= sh_rw;
                            cyc_stb    <= 1'b1;
                            wr_stb     <= ~sh_rw;
                            rom_wr_stb <= ~sh_rw & sh_addr[15];
                            wr_consec  <= prev_wr;
                            prev_wr    <= ~sh_rw;
                        end
                    end
                end
                default: state <= ST_LOW;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_sampler.sv
// Self-checking bench for cpu_bus_sampler: directed table, glitch/reset/idle sequences
// and randomized bus cycles against a cycle-level behavioural model.
module tb_cpu_bus_sampler;
    localparam int unsigned FL   = 3;
    localparam int unsigned IDLE = 1024;
    localparam int          NEVER = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_m2 = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dat = '0;
    logic        cpu_rw = 1'b1;
    logic        m2_f, cyc_stb, wr_stb, rom_wr_stb, bus_rw, wr_consec, bus_idle;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dat;

    cpu_bus_sampler #(.FILTER_LEN(FL), .IDLE_CLKS(IDLE)) dut (
        .clk(clk), .rst(rst), .cpu_m2(cpu_m2), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
        .cpu_rw(cpu_rw), .m2_f(m2_f), .cyc_stb(cyc_stb), .wr_stb(wr_stb),
        .rom_wr_stb(rom_wr_stb), .bus_addr(bus_addr), .bus_dat(bus_dat), .bus_rw(bus_rw),
        .wr_consec(wr_consec), .bus_idle(bus_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  dat;
        logic        rw;
        logic        wr;
        logic        rom;
        logic        consec;
    } stb_t;

    stb_t got_q[$];
    logic [25:0] held = {16'h0, 8'h0, 1'b1, 1'b0};

    // Capture every strobe and check latched outputs only move on cyc_stb.
    always @(negedge clk) begin
        if (cyc_stb || wr_stb || rom_wr_stb) begin
            got_q.push_back('{cyc, bus_addr, bus_dat, bus_rw, wr_stb, rom_wr_stb, wr_consec});
        end
        if (!rst && !cyc_stb) begin
            chk("hold_outputs", 32'({bus_addr, bus_dat, bus_rw, wr_consec}), 32'(held));
        end
        held <= {bus_addr, bus_dat, bus_rw, wr_consec};
    end

    // Model state: filtered-low window [a_low, b_rise] and last-cycle-was-write flag.
    int a_low  = 0;
    int b_rise = NEVER;
    bit prev_write = 1'b0;

    task automatic step(input bit idle_chk);
        @(posedge clk);
        #1;
        if (idle_chk) begin
            chk("bus_idle", 32'(bus_idle),
                32'((cyc >= a_low + int'(IDLE)) && (cyc <= b_rise)));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m2_f"}, 32'(m2_f), 32'(0));
        chk({tag, "_cyc_stb"}, 32'(cyc_stb), 32'(0));
        chk({tag, "_wr_stb"}, 32'(wr_stb), 32'(0));
        chk({tag, "_rom_wr_stb"}, 32'(rom_wr_stb), 32'(0));
        chk({tag, "_bus_addr"}, 32'(bus_addr), 32'(0));
        chk({tag, "_bus_dat"}, 32'(bus_dat), 32'(0));
        chk({tag, "_bus_rw"}, 32'(bus_rw), 32'(1));
        chk({tag, "_wr_consec"}, 32'(wr_consec), 32'(0));
        chk({tag, "_bus_idle"}, 32'(bus_idle), 32'(0));
    endtask

    // One CPU cycle: M2 high for hi clocks then low for lo clocks, checked against the model.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                             input int hi, input int lo, input bit late, output stb_t r);
        stb_t e;
        int   f0;
        cpu_m2   = 1'b1;
        cpu_addr = a;
        cpu_rw   = rw;
        cpu_dat  = late ? 8'h00 : d;
        b_rise   = cyc + 2 + int'(FL);
        for (int i = 0; i < hi; i++) begin
            if (late && i == hi - 4) cpu_dat = d;
            step(1'b1);
        end
        cpu_m2 = 1'b0;
        f0     = cyc + 1;
        a_low  = f0 + 1 + int'(FL);
        b_rise = NEVER;
        e.cyc    = f0 + 2 + int'(FL);
        e.addr   = a;
        e.dat    = d;
        e.rw     = rw;
        e.wr     = !rw;
        e.rom    = !rw && a[15];
        e.consec = prev_write;
        for (int i = 0; i < lo; i++) begin
            if (i == 3) begin
                cpu_addr = 16'($urandom);
                cpu_dat  = 8'($urandom);
                cpu_rw   = 1'($urandom);
            end
            step(1'b1);
        end
        prev_write = !rw && (lo < int'(IDLE));
        chk("strobe_count", 32'(got_q.size()), 32'(1));
        r = '{0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        if (got_q.size() > 0) r = got_q.pop_front();
        got_q.delete();
        chk("strobe_cycle", 32'(r.cyc), 32'(e.cyc));
        chk("bus_addr", 32'(r.addr), 32'(e.addr));
        chk("bus_dat", 32'(r.dat), 32'(e.dat));
        chk("bus_rw", 32'(r.rw), 32'(e.rw));
        chk("wr_stb", 32'(r.wr), 32'(e.wr));
        chk("rom_wr_stb", 32'(r.rom), 32'(e.rom));
        if (!rw) chk("wr_consec", 32'(r.consec), 32'(e.consec));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        int          hi;
        int          lo;
        bit          late;
        logic        exp_rom;
        logic        exp_consec;
    } vec_t;

    vec_t tab[9];

    initial begin
        stb_t r;
        bit   moved;
        int   p;

        tab[0] = '{16'h8000, 8'h80, 1'b0, 20, 36,   1'b0, 1'b1, 1'b0};
        tab[1] = '{16'hE000, 8'h00, 1'b1, 20, 36,   1'b0, 1'b0, 1'b0};
        tab[2] = '{16'hE000, 8'h05, 1'b0, 20, 36,   1'b0, 1'b1, 1'b0};
        tab[3] = '{16'hE000, 8'h01, 1'b0, 20, 36,   1'b0, 1'b1, 1'b1};
        tab[4] = '{16'hA000, 8'h3C, 1'b0, 20, 36,   1'b1, 1'b1, 1'b1};
        tab[5] = '{16'h6000, 8'h55, 1'b0, 20, 36,   1'b0, 1'b0, 1'b1};
        tab[6] = '{16'h8000, 8'h11, 1'b0, 20, 1024, 1'b0, 1'b1, 1'b1};
        tab[7] = '{16'h8001, 8'h22, 1'b0, 20, 1023, 1'b0, 1'b1, 1'b0};
        tab[8] = '{16'h8002, 8'h33, 1'b0, 20, 36,   1'b0, 1'b1, 1'b1};

        // Power-on reset with M2 low.
        repeat (4) step(1'b0);
        check_reset("reset");
        rst = 1'b0;
        a_low = cyc;
        b_rise = NEVER;
        prev_write = 1'b0;
        step(1'b0);

        // Directed table: write, RMW, late data, non-ROM write, idle gaps.
        for (int i = 0; i < 9; i++) begin
            bus_cycle(tab[i].a, tab[i].d, tab[i].rw, tab[i].hi, tab[i].lo, tab[i].late, r);
            chk("tab_rom", 32'(r.rom), 32'(tab[i].exp_rom));
            chk("tab_dat", 32'(r.dat), 32'(tab[i].d));
            if (!tab[i].rw) chk("tab_consec", 32'(r.consec), 32'(tab[i].exp_consec));
        end

        // Glitch rejection: 2-clk low pulse mid-high, 2-clk high pulse mid-low.
        cpu_m2 = 1'b1;
        repeat (12) step(1'b0);
        chk("glitch_pre_high", 32'(m2_f), 32'(1));
        moved = 1'b0;
        cpu_m2 = 1'b0;
        repeat (2) begin step(1'b0); if (!m2_f) moved = 1'b1; end
        cpu_m2 = 1'b1;
        repeat (8) begin step(1'b0); if (!m2_f) moved = 1'b1; end
        chk("glitch_low_2clk", 32'(moved), 32'(0));
        cpu_m2 = 1'b0;
        repeat (12) step(1'b0);
        chk("glitch_pre_low", 32'(m2_f), 32'(0));
        moved = 1'b0;
        cpu_m2 = 1'b1;
        repeat (2) begin step(1'b0); if (m2_f) moved = 1'b1; end
        cpu_m2 = 1'b0;
        repeat (8) begin step(1'b0); if (m2_f) moved = 1'b1; end
        chk("glitch_high_2clk", 32'(moved), 32'(0));
        chk("glitch_strobes", 32'(got_q.size()), 32'(1));
        got_q.delete();

        // A 3-clk pulse does get through the filter.
        p = cyc;
        cpu_m2 = 1'b1;
        repeat (3) step(1'b0);
        cpu_m2 = 1'b0;
        step(1'b0);
        chk("pulse3_before", 32'(m2_f), 32'(0));
        step(1'b0);
        chk("pulse3_toggle", 32'(m2_f), 32'(1));
        chk("pulse3_latency", 32'(cyc - p), 32'(2 + FL));
        repeat (20) step(1'b0);
        got_q.delete();

        // Reset while M2 is high during a write: that cycle must be dropped.
        cpu_m2 = 1'b1;
        cpu_addr = 16'h8000;
        cpu_dat = 8'hAA;
        cpu_rw = 1'b0;
        repeat (10) step(1'b0);
        rst = 1'b1;
        repeat (3) step(1'b0);
        check_reset("rst_mid");
        rst = 1'b0;
        repeat (8) step(1'b0);
        cpu_m2 = 1'b0;
        p = cyc + 1;
        repeat (30) step(1'b0);
        chk("rst_mid_no_strobe", 32'(got_q.size()), 32'(0));
        check_reset("rst_after");
        got_q.delete();
        a_low = p + 1 + int'(FL);
        b_rise = NEVER;
        prev_write = 1'b0;
        bus_cycle(16'hC000, 8'h5A, 1'b0, 20, 40, 1'b0, r);

        // Randomized cycles, occasionally straddling the idle threshold.
        for (int i = 0; i < 150; i++) begin
            int hi, lo;
            hi = int'($urandom_range(30, 8));
            if ($urandom_range(7, 0) == 0) lo = int'($urandom_range(IDLE + 3, IDLE - 3));
            else lo = int'($urandom_range(40, 8));
            bus_cycle(16'($urandom), 8'($urandom), 1'($urandom), hi, lo, 1'($urandom), r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_bus_sampler.md
# cpu_bus_sampler

Front-end stage feeding the mapper register logic (MMC1 serial port and siblings) from the system clock domain. It samples the asynchronous NES CPU bus, deglitches M2, and turns each completed CPU bus cycle into single-clock strobes with latched address, data and R/W. It also raises a consecutive-write flag so that downstream serial-load logic can ignore the second write of a read-modify-write instruction. The end-of-cycle strobe replaces direct clocking of mapper registers on the falling edge of `cpu_m2`.

## Interface
Parameters:
- `FILTER_LEN`, 3: consecutive synchronized samples of the new M2 level required before the filtered M2 changes. Range 1..15.
- `IDLE_CLKS`, 1024: `clk` cycles of filtered M2 low after which the bus is declared idle. Range 2..65535.

Ports:
- `clk`  in  1  system clock, ≥ 32× the M2 frequency. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_m2`  in  1  raw CPU M2, asynchronous.
- `cpu_addr`  in  16  raw CPU address, asynchronous.
- `cpu_dat`  in  8  raw CPU data bus, asynchronous.
- `cpu_rw`  in  1  raw CPU R/W (1 = read), asynchronous.
- `m2_f`  out  1  filtered, synchronized M2.
- `cyc_stb`  out  1  one-clock pulse at the end of every CPU cycle.
- `wr_stb`  out  1  one-clock pulse at the end of a write cycle. Coincides with `cyc_stb`.
- `rom_wr_stb`  out  1  `wr_stb` qualified by `bus_addr[15]==1`.
- `bus_addr`  out  16  address latched for the last completed cycle.
- `bus_dat`  out  8  data latched for the last completed cycle.
- `bus_rw`  out  1  R/W latched for the last completed cycle.
- `wr_consec`  out  1  valid with `wr_stb`: the immediately preceding completed cycle was also a write.
- `bus_idle`  out  1  M2 has been low for `IDLE_CLKS` clocks.

## Operation
- **Synchronization:** every raw input passes through a 2-flop synchronizer. Outputs of the synchronizers are `m2_s`, `addr_s`, `dat_s`, `rw_s`.
- **M2 filter:**
  - A 4-bit counter counts consecutive clocks where `m2_s != m2_f`. It clears whenever `m2_s == m2_f`.
  - When the count would reach `FILTER_LEN`, `m2_f` toggles on that edge and the counter clears.
  - A shorter glitch never changes `m2_f`.
- **State machine:** two states, LOW and HIGH, following `m2_f`. An `armed` bit is set on entry to HIGH.
  - In HIGH, each clk where `m2_s==1`: shadow registers load `addr_s`, `dat_s` and `rw_s`.
  - Samples are not taken once `m2_s` falls, during the filter window. The last sample before the fall is kept, which is the late-valid write data.
  - HIGH→LOW while `armed`: `bus_addr`, `bus_dat` and `bus_rw` load from the shadows. `cyc_stb` pulses.
    - If the shadow R/W is 0, `wr_stb` also pulses.
    - `rom_wr_stb` pulses if, in addition, the shadow `addr[15]` is 1.
    - `armed` clears.
- **Consecutive-write tracking:**
  - A `prev_wr` bit holds the R/W of the last completed cycle (1 = that cycle was a write).
  - `wr_consec` = `prev_wr` at the moment of the strobe.
  - `prev_wr` updates on each `cyc_stb`.
- **Idle detection:**
  - A 16-bit counter increments while in LOW and saturates at `IDLE_CLKS`.
  - When the count reaches `IDLE_CLKS`, `bus_idle`=1 and `prev_wr` clears, so a write after a bus stall is never consecutive.
  - Entering HIGH clears the counter and `bus_idle`.
- **Reset:** `m2_f`, all strobes, `bus_addr`, `bus_dat`, `wr_consec`, `bus_idle`, `prev_wr`, `armed`, shadows and counters are 0. `bus_rw`=1.
  - A falling edge seen without a rising edge after reset produces no strobe, so a cycle cut by reset is discarded.
- **Simultaneous events:** reset dominates. The idle counter cannot reach its limit in the same clock as a HIGH entry, because HIGH entry clears it first.

## Timing
- **Strobe latency:** strobes assert exactly 2 + `FILTER_LEN` clocks after the first `clk` edge that samples raw `cpu_m2` low, assuming no glitch. Strobes are high for exactly one clock.
- **`m2_f` rise latency:** 2 + `FILTER_LEN` clocks after the raw rise.
- **Output stability:** `bus_addr`, `bus_dat`, `bus_rw` and `wr_consec` change only on the strobe edge and hold until the next `cyc_stb`.
- **Strobe spacing:** at most one `cyc_stb` per M2 period. There are no back-to-back strobes, because the minimum spacing is 2·`FILTER_LEN` clocks.
- **Idle latency:** `bus_idle` rises `IDLE_CLKS` clocks after `m2_f` falls.

## Test plan
- **Single write:** reset, then M2 20 clk high / 36 low with addr=$8000, data=$80, rw=0 → exactly one `wr_stb` and `rom_wr_stb` 5 clk after the raw fall, `bus_addr`=$8000, `bus_dat`=$80, `wr_consec`=0.
- **Read-modify-write:** read $E000, write $E000 data $05, write $E000 data $01 on three consecutive cycles → `cyc_stb`×3, `wr_stb`×2, `wr_consec`=0 on the first write and 1 on the second.
- **Glitch rejection:** 2-clk low pulse on M2 mid-HIGH, and 2-clk high pulse mid-LOW → no strobes, `m2_f` unchanged. A 3-clk pulse toggles `m2_f`.
- **Late data:** data changes $00→$3C 4 clk before the M2 fall on a write to $A000 → `bus_dat`=$3C. A write to $6000 → `wr_stb`=1, `rom_wr_stb`=0.
- **Idle:** write, hold M2 low 1024 clk, write → `bus_idle` asserts at clock 1024 and clears on the M2 rise, second write has `wr_consec`=0. With a 1023-clk gap → `wr_consec`=1.
- **Reset mid-cycle:** assert `rst` while M2 is high during a write, release before the fall → no strobe for that cycle, all outputs at reset values, next full cycle strobes normally.
